decade_gate_sequencer: RTL and testbench
========================================

// Module: decade_gate_sequencer
// PURPOSE
//  Gated event counter controller built around a chain of cascaded decade (BCD) digits.
//  On command, it counts event strobes for a fixed window of GATE_CYCLES clocks.
//  It then freezes the BCD result and offers it to a consumer through a valid/ready handshake.
//  Sits between event sources (e.g. edge detectors) and display/readout logic.
//  Sequences clear, count and report of the decade chain, which is fully synchronous to clk.
// PARAMETERS
//  DIGITS       4     number of cascaded decade digits (result width 4*DIGITS)
//  GATE_CYCLES  1000  length of the count window in clk cycles (>=1)
//  GATE_W       16    gate counter width; must hold GATE_CYCLES-1
// PORTS
//  clk         in   1         system clock, rising edge
//  reset       in   1         reset, asynchronous, active-low
//  start_i     in   1         begin a measurement (sampled in IDLE only)
//  stop_i      in   1         abort a running measurement
//  event_i     in   1         one-cycle event strobe, counted while in COUNT
//  busy_o      out  1         1 when state != IDLE
//  count_o     out  4*DIGITS  live BCD count, digit 0 in [3:0]
//  result_o    out  4*DIGITS  BCD result latched at end of window
//  overflow_o  out  1         result wrapped past all-9s (latched with result)
//  valid_o     out  1         result_o/overflow_o valid
//  ready_i     in   1         consumer accepts result when valid_o & ready_i
// BEHAVIOUR
//  Reset (reset=0, any time, incl. mid-count):
//   - FSM=IDLE; gate counter=0.
//   - count_o, result_o, overflow_o, valid_o and busy_o all 0.
//   - Takes effect immediately, without waiting for clk.
//  FSM states: IDLE, COUNT, REPORT.
//  IDLE:
//   - start_i=1 & stop_i=0 at edge k: clear count_o, gate counter and sticky overflow; go to COUNT.
//   - stop_i wins over start_i when both are 1.
//   - event_i is ignored in IDLE, including the start cycle.
//  COUNT:
//   - Each edge increments the gate counter.
//   - event_i=1 at an edge increments count_o by 1 (decimal).
//   - BCD rule: a digit at 9 becomes 0 and carries into the next digit.
//   - A carry out of the top digit wraps count_o to 0 and sets sticky overflow.
//   - Window = edges k+1 .. k+GATE_CYCLES, exactly GATE_CYCLES samples of event_i.
//   - At edge k+GATE_CYCLES: the event in that cycle is included.
//     result_o = final count; overflow_o = sticky overflow; valid_o=1; go to REPORT.
//   - stop_i=1 at an edge: go to IDLE.
//     result_o/overflow_o are unchanged, valid_o stays 0, count_o holds the partial value.
//   - start_i is ignored in COUNT.
//  REPORT:
//   - valid_o held at 1; result_o/overflow_o stable until the handshake.
//   - On valid_o & ready_i at an edge: valid_o=0, go to IDLE.
//   - start_i and stop_i are ignored; a new start is accepted from IDLE only.
//   - ready_i=1 in the REPORT entry cycle completes the handshake one edge after valid_o rises.
//  Latency:
//   - start sampled at edge k -> valid_o=1 after edge k+GATE_CYCLES.
//   - Minimum restart: IDLE one cycle after the handshake.
//  Outside REPORT:
//   - result_o keeps its last latched value.
//   - busy_o is 1 in COUNT and REPORT.
// TESTING (bench overrides noted)
//  1 DIGITS=2, GATE=20; start, event_i=1 every cycle
//    -> valid_o after 20 edges, result_o=8'h20, overflow_o=0.
//  2 DIGITS=2, GATE=120; event every cycle
//    -> result_o=8'h20, overflow_o=1; count_o passes 8'h99 -> 8'h00.
//  3 Event every other cycle
//    -> count_o steps 8'h09 -> 8'h10 (decimal carry), never 8'h0A.
//  4 ready_i low 5 cycles in REPORT, start_i pulsed
//    -> valid_o stays 1, result_o stable, start ignored; ready_i=1 -> IDLE next edge.
//  5 stop_i at gate cycle 7
//    -> busy_o=0 next edge, valid_o never rises, result_o keeps its prior value.
//  6 reset low mid-COUNT, between edges
//    -> all outputs 0 immediately; after release, start_i works normally.

Source files
------------

// File: rtl/decade_gate_sequencer.sv
// Gated event counter: clears a cascaded BCD chain, counts event strobes for a fixed
// window of clock cycles, then holds the frozen result on a valid/ready output.
module decade_gate_sequencer #(
  parameter int DIGITS      = 4,
  parameter int GATE_CYCLES = 1000,
  parameter int GATE_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic                  event_i,
  output logic                  busy_o,
  output logic [4*DIGITS-1:0]   count_o,
  output logic [4*DIGITS-1:0]   result_o,
  output logic                  overflow_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [1:0]            state_o
);

  localparam int W = 4 * DIGITS;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

  // Handshake: the result is transferred on a rising edge where valid_o & ready_i.
  // valid_o rises only on entry to REPORT and never drops until that transfer.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_COUNT  = 2'd1,
    S_REPORT = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [GATE_W-1:0]   gate_q, gate_d;
  logic [W-1:0]        count_q, count_d;
  logic [W-1:0]        result_q, result_d;
  logic                ovf_q, ovf_d;
  logic                result_ovf_q, result_ovf_d;
  logic [W-1:0]        count_inc;
  logic                carry_top;

  // Decimal increment of the whole chain; carry_top flags a wrap past all-9s.
  always_comb begin
    logic carry;
    carry     = 1'b1;
    count_inc = count_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (count_q[4*i +: 4] == 4'd9) begin
          count_inc[4*i +: 4] = 4'd0;
        end else begin
          count_inc[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
    carry_top = carry;
  end

  always_comb begin
    state_d      = state_q;
    gate_d       = gate_q;
    count_d      = count_q;
    ovf_d        = ovf_q;
    result_d     = result_q;
    result_ovf_d = result_ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start_i && !stop_i) begin
          state_d = S_COUNT;
          gate_d  = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end
      S_COUNT: begin
        // An abort leaves the partial count visible and the last result untouched.
        if (stop_i) begin
          state_d = S_IDLE;
        end else begin
          gate_d = gate_q + 1'b1;
          if (event_i) begin
            count_d = count_inc;
            if (carry_top) ovf_d = 1'b1;
          end
          if (gate_q == GATE_LAST) begin
            state_d      = S_REPORT;
            result_d     = count_d;
            result_ovf_d = ovf_d;
          end
        end
      end
      S_REPORT: begin
        if (ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      gate_q       <= '0;
      count_q      <= '0;
      ovf_q        <= 1'b0;
      result_q     <= '0;
      result_ovf_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      gate_q       <= gate_d;
      count_q      <= count_d;
      ovf_q        <= ovf_d;
      result_q     <= result_d;
      result_ovf_q <= result_ovf_d;
    end
  end

  assign busy_o     = (state_q != S_IDLE);
  assign valid_o    = (state_q == S_REPORT);
  assign count_o    = count_q;
  assign result_o   = result_q;
  assign overflow_o = result_ovf_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_decade_gate_sequencer.sv
// Directed bench for decade_gate_sequencer with a two-digit chain and a 120-cycle window.
module tb_decade_gate_sequencer;

  localparam int DIGITS = 2;
  localparam int GATE   = 120;
  localparam int W      = 4 * DIGITS;

  logic         clk;
  logic         reset;
  logic         start_i;
  logic         stop_i;
  logic         event_i;
  logic         ready_i;
  logic         busy_o;
  logic [W-1:0] count_o;
  logic [W-1:0] result_o;
  logic         overflow_o;
  logic         valid_o;
  logic [1:0]   state_o;

  decade_gate_sequencer #(.DIGITS(DIGITS), .GATE_CYCLES(GATE), .GATE_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_i    (start_i),
    .stop_i     (stop_i),
    .event_i    (event_i),
    .busy_o     (busy_o),
    .count_o    (count_o),
    .result_o   (result_o),
    .overflow_o (overflow_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .state_o    (state_o)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic saw_09_10 = 1'b0;
  logic saw_99_00 = 1'b0;
  logic bad_bcd   = 1'b0;

  typedef struct {
    int         period;
    int         limit;
    logic [7:0] exp_result;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // One full measurement: start at edge k, event every `period` window cycles within
  // the first `limit` cycles, then a single-cycle handshake.
  task automatic run_measure(input int period, input int limit,
                             input logic [7:0] exp_res, input logic exp_ovf, input string tag);
    logic       early;
    logic [7:0] prev;
    @(negedge clk);
    start_i = 1'b1;
    event_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    check({tag, "_busy_after_start"}, busy_o, 1);
    check({tag, "_count_cleared"}, count_o, 0);
    early = 1'b0;
    prev  = count_o;
    for (int j = 1; j <= GATE; j++) begin
      event_i = (period != 0) && (j <= limit) && (((j - 1) % period) == 0);
      @(negedge clk);
      if (j < GATE && valid_o) early = 1'b1;
      if (count_o[3:0] > 4'd9 || count_o[7:4] > 4'd9) bad_bcd = 1'b1;
      if (prev == 8'h09 && count_o == 8'h10) saw_09_10 = 1'b1;
      if (prev == 8'h99 && count_o == 8'h00) saw_99_00 = 1'b1;
      prev = count_o;
    end
    event_i = 1'b0;
    check({tag, "_no_early_valid"}, early, 0);
    check({tag, "_valid"}, valid_o, 1);
    check({tag, "_result"}, result_o, exp_res);
    check({tag, "_overflow"}, overflow_o, exp_ovf);
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
    check({tag, "_valid_dropped"}, valid_o, 0);
    check({tag, "_idle_after_hs"}, busy_o, 0);
  endtask

  initial begin
    vecs[0] = '{period: 1, limit: 20,  exp_result: 8'h20, exp_ovf: 1'b0};
    vecs[1] = '{period: 1, limit: 120, exp_result: 8'h20, exp_ovf: 1'b1};
    vecs[2] = '{period: 2, limit: 120, exp_result: 8'h60, exp_ovf: 1'b0};
    vecs[3] = '{period: 3, limit: 120, exp_result: 8'h40, exp_ovf: 1'b0};
    vecs[4] = '{period: 0, limit: 120, exp_result: 8'h00, exp_ovf: 1'b0};
    vecs[5] = '{period: 1, limit: 99,  exp_result: 8'h99, exp_ovf: 1'b0};
    vecs[6] = '{period: 1, limit: 100, exp_result: 8'h00, exp_ovf: 1'b1};
    vecs[7] = '{period: 1, limit: 119, exp_result: 8'h19, exp_ovf: 1'b1};

    reset   = 1'b0;
    start_i = 1'b0;
    stop_i  = 1'b0;
    event_i = 1'b0;
    ready_i = 1'b0;
    #1;
    check("rst_busy", busy_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_count", count_o, 0);
    check("rst_result", result_o, 0);
    check("rst_overflow", overflow_o, 0);
    check("rst_state", state_o, 0);
    @(negedge clk);
    reset = 1'b1;

    // Both start and stop high in IDLE: stop wins.
    @(negedge clk);
    start_i = 1'b1;
    stop_i  = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    stop_i  = 1'b0;
    check("start_stop_stays_idle", busy_o, 0);

    for (int v = 0; v < 8; v++)
      run_measure(vecs[v].period, vecs[v].limit, vecs[v].exp_result, vecs[v].exp_ovf,
                  $sformatf("vec%0d", v));
    check("bcd_digits_valid", bad_bcd, 0);
    check("carry_09_to_10", saw_09_10, 1);
    check("wrap_99_to_00", saw_99_00, 1);

    // Consumer stalls in REPORT while start/stop toggle.
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    for (int j = 1; j <= GATE; j++) begin
      event_i = (j <= 5);
      @(negedge clk);
    end
    event_i = 1'b0;
    for (int c = 0; c < 5; c++) begin
      start_i = (c == 1);
      stop_i  = (c == 3);
      @(negedge clk);
      check($sformatf("stall_valid_%0d", c), valid_o, 1);
      check($sformatf("stall_result_%0d", c), result_o, 8'h05);
    end
    start_i = 1'b0;
    stop_i  = 1'b0;
    check("stall_count_held", count_o, 8'h05);
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
    check("stall_hs_idle", busy_o, 0);
    check("stall_hs_valid", valid_o, 0);

    // Abort at gate cycle 7.
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    event_i = 1'b1;
    for (int j = 1; j < 7; j++) @(negedge clk);
    check("abort_busy_before", busy_o, 1);
    stop_i = 1'b1;
    @(negedge clk);
    stop_i  = 1'b0;
    check("abort_busy", busy_o, 0);
    check("abort_result_kept", result_o, 8'h05);
    begin
      logic rose;
      rose = 1'b0;
      for (int j = 0; j < GATE + 10; j++) begin
        @(negedge clk);
        if (valid_o || busy_o) rose = 1'b1;
      end
      check("abort_no_valid", rose, 0);
    end
    event_i = 1'b0;

    // Asynchronous reset in the middle of COUNT, between edges.
    @(negedge clk);
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    event_i = 1'b1;
    for (int j = 0; j < 4; j++) @(negedge clk);
    check("pre_reset_count", count_o, 8'h04);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async_busy", busy_o, 0);
    check("async_count", count_o, 0);
    check("async_result", result_o, 0);
    check("async_valid", valid_o, 0);
    check("async_overflow", overflow_o, 0);
    event_i = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    run_measure(1, 33, 8'h33, 1'b0, "post_reset");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
